// File: rtl/row_pixel_serializer.sv
// Row-to-pixel serializer: takes one whole filtered row and streams its pixels,
// one per pix_valid/pix_ready handshake, tagged with start-of-frame, end-of-line and end-of-frame.
module row_pixel_serializer #(
  parameter int COLS  = 256,
  parameter int ROWS  = 256,
  parameter int WIDTH = 8,
  localparam int PW = 3*WIDTH,
  localparam int RW = COLS*PW,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int NW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [RW-1:0] row_in,
  input  logic          frm_clr,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [PW-1:0] pix_data,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_eof,
  output logic [NW-1:0] row_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, next_state;
  logic [CW-1:0] col;
  logic [RW-1:0] row_reg;
  logic          last_col;
  logic          pix_xfer;
  logic          last_xfer;
  logic          row_acc;

  assign last_col  = (col == CW'(COLS-1));
  assign pix_xfer  = (state == SEND) && pix_ready;
  assign last_xfer = pix_xfer && last_col;
  assign row_ready = (state == IDLE) || last_xfer;
  assign row_acc   = row_valid && row_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (row_acc) next_state = SEND;
      SEND:    if (last_xfer && !row_acc) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col     <= '0;
      row_cnt <= '0;
    end else begin
      if (pix_xfer) col <= last_col ? '0 : col + CW'(1);
      if (frm_clr)
        row_cnt <= '0;
      else if (last_xfer)
        row_cnt <= (row_cnt == NW'(ROWS-1)) ? '0 : row_cnt + NW'(1);
    end
  end

  // The pixel being presented always sits in the top PW bits; each transfer shifts the next one up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      row_reg <= '0;
    else if (row_acc)
      row_reg <= row_in;
    else if (pix_xfer)
      row_reg <= {row_reg[RW-PW-1:0], {PW{1'b0}}};
  end

  always_comb begin
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    pix_eof   = 1'b0;
    if (state == SEND) begin
      pix_valid = 1'b1;
      pix_data  = row_reg[RW-1 -: PW];
      pix_sof   = (col == '0) && (row_cnt == '0);
      pix_eol   = last_col;
      pix_eof   = last_col && (row_cnt == NW'(ROWS-1));
    end
  end

endmodule

// File: tb/tb_row_pixel_serializer.sv
// Bench for row_pixel_serializer: a fixed vector table for the first row, then randomized
// traffic checked every cycle against a row/column-level reference model.
module tb_row_pixel_serializer;

  localparam int COLS  = 16;
  localparam int ROWS  = 8;
  localparam int WIDTH = 8;
  localparam int PW = 3*WIDTH;
  localparam int RW = COLS*PW;
  localparam int NW = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          row_valid = 1'b0;
  logic          row_ready;
  logic [RW-1:0] row_in = '0;
  logic          frm_clr = 1'b0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [PW-1:0] pix_data;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic [NW-1:0] row_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the row being emitted as a pixel array, plus column/row position.
  logic [PW-1:0] m_pix [COLS];
  bit            m_busy;
  int            m_col;
  int            m_row;

  typedef struct {
    bit rv, pr, fc;
    bit e_valid, e_ready, e_sof, e_eol, e_eof;
    int e_k;
    int e_row;
  } vec_t;
  vec_t tbl[$];

  row_pixel_serializer #(.COLS(COLS), .ROWS(ROWS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .row_valid(row_valid), .row_ready(row_ready), .row_in(row_in),
    .frm_clr(frm_clr), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .row_cnt(row_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [PW-1:0] pat(input int k);
    logic [7:0] kb;
    kb = k[7:0];
    return {kb, ~kb, 8'hA5};
  endfunction

  function automatic void add_vec(input bit rv, pr, fc, e_valid, e_ready, e_sof, e_eol, e_eof,
                                  input int e_k, e_row);
    vec_t v;
    v = '{rv: rv, pr: pr, fc: fc, e_valid: e_valid, e_ready: e_ready, e_sof: e_sof,
          e_eol: e_eol, e_eof: e_eof, e_k: e_k, e_row: e_row};
    tbl.push_back(v);
  endfunction

  task automatic apply_stimulus(input bit rv, input bit pr, input bit fc);
    row_valid = rv;
    pix_ready = pr;
    frm_clr   = fc;
  endtask

  task automatic pattern_row();
    for (int k = 0; k < COLS; k++) row_in[RW-1-k*PW -: PW] = pat(k);
  endtask

  task automatic random_row();
    for (int k = 0; k < COLS; k++) row_in[RW-1-k*PW -: PW] = PW'($urandom);
  endtask

  task automatic check_output(input string name, input bit e_valid, input bit e_ready,
                              input logic [PW-1:0] e_data, input bit e_sof, input bit e_eol,
                              input bit e_eof, input int e_row, input bit use_ready);
    vectors++;
    if (pix_valid !== e_valid || (use_ready && row_ready !== e_ready) || pix_data !== e_data ||
        pix_sof !== e_sof || pix_eol !== e_eol || pix_eof !== e_eof || row_cnt !== NW'(e_row)) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got v=%b rdy=%b d=%h sof=%b eol=%b eof=%b cnt=%0d, want v=%b rdy=%b d=%h sof=%b eol=%b eof=%b cnt=%0d",
               name, $time, pix_valid, row_ready, pix_data, pix_sof, pix_eol, pix_eof, row_cnt,
               e_valid, e_ready, e_data, e_sof, e_eol, e_eof, e_row);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_col  = 0;
    m_row  = 0;
  endtask

  // One clock cycle: compare outputs mid-cycle against the model, then advance the model.
  task automatic model_cycle(input string name);
    bit e_ready;
    @(negedge clk);
    if (!rst) begin
      check_output(name, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end else begin
      e_ready = !m_busy || (m_col == COLS-1 && pix_ready);
      check_output(name, m_busy, e_ready, m_busy ? m_pix[m_col] : '0,
                   m_busy && m_col == 0 && m_row == 0,
                   m_busy && m_col == COLS-1,
                   m_busy && m_col == COLS-1 && m_row == ROWS-1, m_row, 1'b1);
      if (m_busy && pix_ready) begin
        if (m_col == COLS-1) begin
          m_col  = 0;
          m_row  = (m_row + 1) % ROWS;
          m_busy = 1'b0;
        end else begin
          m_col++;
        end
      end
      if (frm_clr) m_row = 0;
      if (row_valid && e_ready) begin
        m_busy = 1'b1;
        for (int k = 0; k < COLS; k++) m_pix[k] = row_in[RW-1-k*PW -: PW];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) model_cycle("reset");
    rst = 1'b1;
  endtask

  task automatic run_until(input string name, input int row, input int c);
    int budget;
    budget = 0;
    while (!(m_busy && m_row == row && m_col == c) && budget < 500) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      random_row();
      model_cycle(name);
      budget++;
    end
    vectors++;
    if (budget >= 500) begin
      miscompares++;
      $display("[TB] FAIL %s: position row %0d col %0d not reached, got row %0d col %0d", name, row, c, m_row, m_col);
    end
  endtask

  initial begin
    // First row after reset: accept, stall, then full stream with pix_ready high.
    add_vec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add_vec(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k < COLS; k++)
      add_vec(0, 1, 0, 1, k == COLS-1, 0, k == COLS-1, 0, k, 0);
    add_vec(0, 1, 1, 0, 1, 0, 0, 0, 0, 1);
    add_vec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);

    do_reset();
    pattern_row();
    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].rv, tbl[i].pr, tbl[i].fc);
      @(negedge clk);
      check_output($sformatf("table[%0d]", i), tbl[i].e_valid, tbl[i].e_ready,
                   tbl[i].e_valid ? pat(tbl[i].e_k) : '0, tbl[i].e_sof, tbl[i].e_eol,
                   tbl[i].e_eof, tbl[i].e_row, 1'b1);
      @(posedge clk);
      #1;
    end

    // A whole frame plus one row back-to-back: no bubbles, eof on last pixel, wrap to sof.
    do_reset();
    for (int i = 0; i < ROWS*COLS + COLS + 2; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      random_row();
      model_cycle("back_to_back");
    end

    // Random row_valid / pix_ready with occasional frame resync.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      apply_stimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      random_row();
      model_cycle("random");
    end

    // Resync mid-row, then resync coinciding with a last-column transfer.
    do_reset();
    run_until("to_r5c10", 5, 10);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    model_cycle("frm_clr_mid");
    run_until("to_r2_last", 2, COLS-1);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    model_cycle("frm_clr_last");
    for (int i = 0; i < 2*COLS; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      random_row();
      model_cycle("after_clr");
    end

    // Asynchronous reset in the middle of row 3, then a fresh row.
    run_until("to_r3c5", 3, 5);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check_output("async_reset", 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom));
      random_row();
      model_cycle("in_reset");
    end
    rst = 1'b1;
    for (int i = 0; i < COLS + 4; i++) begin
      apply_stimulus(i < 2, 1'b1, 1'b0);
      random_row();
      model_cycle("after_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
